// File: rtl/flash_arb_pkg.sv
// Shared types and pad constants for the flash bus arbiter.
package flash_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2,
    TURN  = 2'd3
  } arb_state_e;

  // WP/HOLD driven high, DQ0/DQ1 released
  localparam logic [3:0] PAD_IDLE_OUT = 4'b1100;
  localparam logic [3:0] PAD_IDLE_OE  = 4'b1100;
  // legacy SPI: DQ0 = MOSI driven, DQ1 = MISO input, WP/HOLD driven
  localparam logic [3:0] SPI_A_OE     = 4'b1101;

endpackage

// File: rtl/flash_bus_arbiter_if.sv
// Master-side and pad-side signals of the flash bus arbiter.
interface flash_bus_arbiter_if;
  logic       iA_REQ;
  logic       oA_GNT;
  logic       iA_CSn;
  logic       iA_SCK;
  logic       iA_MOSI;
  logic       oA_MISO;
  logic       iB_REQ;
  logic       oB_GNT;
  logic       iB_CSn;
  logic       iB_SCK;
  logic [3:0] iB_DQ_OUT;
  logic [3:0] iB_DQ_OE;
  logic [3:0] oB_DQ_IN;
  logic       oFLASH_SCK;
  logic       oFLASH_CSn;
  logic [3:0] oFLASH_DQ_OUT;
  logic [3:0] oFLASH_DQ_OE;
  logic [3:0] iFLASH_DQ_IN;
  logic       oVIOL;

  // arbiter side
  modport slave (
    input  iA_REQ, iA_CSn, iA_SCK, iA_MOSI,
    input  iB_REQ, iB_CSn, iB_SCK, iB_DQ_OUT, iB_DQ_OE,
    input  iFLASH_DQ_IN,
    output oA_GNT, oA_MISO, oB_GNT, oB_DQ_IN,
    output oFLASH_SCK, oFLASH_CSn, oFLASH_DQ_OUT, oFLASH_DQ_OE, oVIOL
  );

  // masters + pads side
  modport master (
    output iA_REQ, iA_CSn, iA_SCK, iA_MOSI,
    output iB_REQ, iB_CSn, iB_SCK, iB_DQ_OUT, iB_DQ_OE,
    output iFLASH_DQ_IN,
    input  oA_GNT, oA_MISO, oB_GNT, oB_DQ_IN,
    input  oFLASH_SCK, oFLASH_CSn, oFLASH_DQ_OUT, oFLASH_DQ_OE, oVIOL
  );
endinterface

// File: rtl/flash_bus_arbiter_pad_mux.sv
// Registered owner select onto the flash pads; idle defaults when nobody owns.
module flash_pad_mux
  import flash_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sel_a,
  input  logic       sel_b,
  input  logic       a_csn,
  input  logic       a_sck,
  input  logic       a_mosi,
  input  logic       b_csn,
  input  logic       b_sck,
  input  logic [3:0] b_dq_out,
  input  logic [3:0] b_dq_oe,
  output logic       pad_sck,
  output logic       pad_csn,
  output logic [3:0] pad_dq_out,
  output logic [3:0] pad_dq_oe
);

  logic       sck_d, csn_d, sck_q, csn_q;
  logic [3:0] out_d, oe_d, out_q, oe_q;

  // next pad value from the current owner; WP/HOLD forced high when B releases them
  always_comb begin
    sck_d = 1'b0;
    csn_d = 1'b1;
    out_d = PAD_IDLE_OUT;
    oe_d  = PAD_IDLE_OE;
    if (sel_a) begin
      sck_d = a_sck;
      csn_d = a_csn;
      out_d = {3'b110, a_mosi};
      oe_d  = SPI_A_OE;
    end else if (sel_b) begin
      sck_d = b_sck & ~b_csn;
      csn_d = b_csn;
      out_d = {b_dq_oe[3] ? b_dq_out[3] : 1'b1,
               b_dq_oe[2] ? b_dq_out[2] : 1'b1,
               b_dq_out[1:0]};
      oe_d  = {2'b11, b_dq_oe[1:0]};
    end
  end

  // pad registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q <= 1'b0;
      csn_q <= 1'b1;
      out_q <= PAD_IDLE_OUT;
      oe_q  <= PAD_IDLE_OE;
    end else begin
      sck_q <= sck_d;
      csn_q <= csn_d;
      out_q <= out_d;
      oe_q  <= oe_d;
    end
  end

  assign pad_sck    = sck_q;
  assign pad_csn    = csn_q;
  assign pad_dq_out = out_q;
  assign pad_dq_oe  = oe_q;

endmodule

// File: rtl/flash_bus_arbiter.sv
// Request/grant arbiter sharing one QSPI pin set between a legacy SPI master (A)
// and a quad-SPI controller (B). Ownership only changes at CS-high boundaries,
// followed by a fixed CS-high turnaround.
module flash_bus_arbiter
  import flash_arb_pkg::*;
#(
  parameter int TURN_CYCLES = 4,
  parameter int IDLE_REVOKE = 64,
  parameter int CNT_W       = 8
) (
  input  logic iCLK,
  input  logic iRESET,
  flash_bus_arbiter_if.slave bus
);

  if (IDLE_REVOKE >= 2**CNT_W || TURN_CYCLES >= 2**CNT_W) begin : g_cnt_w_check
    $error("flash_bus_arbiter: CNT_W too narrow for IDLE_REVOKE/TURN_CYCLES");
  end
  if (TURN_CYCLES < 1 || IDLE_REVOKE < 2) begin : g_param_check
    $error("flash_bus_arbiter: TURN_CYCLES must be >=1 and IDLE_REVOKE >=2");
  end

  localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] REVOKE_LAST = CNT_W'(IDLE_REVOKE - 1);

  arb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             a_gnt_q, b_gnt_q;
  logic             last_b_q;   // last-served port was B
  logic             prev_b_q;   // current/previous owner is B
  logic             viol_d, viol_q;

  logic             own_req, own_csn, oth_req;
  logic [CNT_W-1:0] cnt_inc;

  // owner-relative view of the request/CS inputs; saturating increment
  always_comb begin
    own_req = (state_q == OWN_B) ? bus.iB_REQ : bus.iA_REQ;
    own_csn = (state_q == OWN_B) ? bus.iB_CSn : bus.iA_CSn;
    oth_req = (state_q == OWN_B) ? bus.iA_REQ : bus.iB_REQ;
    cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  end

  // ownership FSM with registered grants and the shared turnaround/idle counter
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_gnt_q  <= 1'b0;
      b_gnt_q  <= 1'b0;
      last_b_q <= 1'b1;
      prev_b_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (bus.iA_REQ && (!bus.iB_REQ || last_b_q)) begin
            state_q  <= OWN_A;
            a_gnt_q  <= 1'b1;
            prev_b_q <= 1'b0;
          end else if (bus.iB_REQ) begin
            state_q  <= OWN_B;
            b_gnt_q  <= 1'b1;
            prev_b_q <= 1'b1;
          end
        end
        OWN_A, OWN_B: begin
          if (own_csn && (!own_req || (oth_req && cnt_q == REVOKE_LAST))) begin
            // voluntary release, or idle owner revoked while the other waits
            state_q <= TURN;
            cnt_q   <= TURN_LOAD;
            a_gnt_q <= 1'b0;
            b_gnt_q <= 1'b0;
          end else if (own_csn && oth_req) begin
            cnt_q <= cnt_inc;
          end else begin
            cnt_q <= '0;
          end
        end
        TURN: begin
          if (cnt_q == '0) begin
            state_q  <= IDLE;
            last_b_q <= prev_b_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // a non-owner pulling its CS low is flagged; its pins never reach the pads
  always_comb begin
    viol_d = (!a_gnt_q && !bus.iA_CSn) || (!b_gnt_q && !bus.iB_CSn);
  end

  // violation pulse register
  always_ff @(posedge iCLK) begin
    if (iRESET) viol_q <= 1'b0;
    else        viol_q <= viol_d;
  end

  flash_pad_mux u_pad_mux (
    .clk        (iCLK),
    .rst        (iRESET),
    .sel_a      (a_gnt_q),
    .sel_b      (b_gnt_q),
    .a_csn      (bus.iA_CSn),
    .a_sck      (bus.iA_SCK),
    .a_mosi     (bus.iA_MOSI),
    .b_csn      (bus.iB_CSn),
    .b_sck      (bus.iB_SCK),
    .b_dq_out   (bus.iB_DQ_OUT),
    .b_dq_oe    (bus.iB_DQ_OE),
    .pad_sck    (bus.oFLASH_SCK),
    .pad_csn    (bus.oFLASH_CSn),
    .pad_dq_out (bus.oFLASH_DQ_OUT),
    .pad_dq_oe  (bus.oFLASH_DQ_OE)
  );

  assign bus.oA_GNT   = a_gnt_q;
  assign bus.oB_GNT   = b_gnt_q;
  assign bus.oVIOL    = viol_q;
  assign bus.oA_MISO  = bus.iFLASH_DQ_IN[1];
  assign bus.oB_DQ_IN = bus.iFLASH_DQ_IN;

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Directed bench for flash_bus_arbiter: grant latency, tie-break, turnaround,
// mid-frame hold, idle revocation, violation flag and mid-transfer reset.
module tb_flash_bus_arbiter;

  logic iCLK = 1'b0;
  logic iRESET;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 iCLK = ~iCLK;

  flash_bus_arbiter_if bus ();

  flash_bus_arbiter #(.TURN_CYCLES(4), .IDLE_REVOKE(64), .CNT_W(8)) dut (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // advance n clocks, sample 1ns after the edge
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic chk_pad_idle(input string tag);
    chk({tag, ".csn"}, 8'(bus.oFLASH_CSn), 8'd1);
    chk({tag, ".sck"}, 8'(bus.oFLASH_SCK), 8'd0);
    chk({tag, ".out"}, 8'(bus.oFLASH_DQ_OUT), 8'b1100);
    chk({tag, ".oe"},  8'(bus.oFLASH_DQ_OE), 8'b1100);
  endtask

  initial begin
    iRESET = 1'b1;
    bus.iA_REQ = 0; bus.iA_CSn = 1; bus.iA_SCK = 0; bus.iA_MOSI = 0;
    bus.iB_REQ = 0; bus.iB_CSn = 1; bus.iB_SCK = 0;
    bus.iB_DQ_OUT = 4'h0; bus.iB_DQ_OE = 4'h0; bus.iFLASH_DQ_IN = 4'b0110;
    step(2);
    iRESET = 1'b0;

    // reset state and input routing
    chk("rst.a_gnt", 8'(bus.oA_GNT), 8'd0);
    chk("rst.b_gnt", 8'(bus.oB_GNT), 8'd0);
    chk("rst.viol",  8'(bus.oVIOL), 8'd0);
    chk_pad_idle("rst");
    chk("miso", 8'(bus.oA_MISO), 8'd1);
    chk("b_dq_in", 8'(bus.oB_DQ_IN), 8'b0110);

    // A alone: 1-cycle grant, pads one cycle after inputs
    bus.iA_REQ = 1;
    step();
    chk("a1.gnt", 8'(bus.oA_GNT), 8'd1);
    chk_pad_idle("a1.pad_pre");
    bus.iA_CSn = 0; bus.iA_SCK = 1; bus.iA_MOSI = 1;
    step();
    chk("a1.csn", 8'(bus.oFLASH_CSn), 8'd0);
    chk("a1.sck", 8'(bus.oFLASH_SCK), 8'd1);
    chk("a1.out", 8'(bus.oFLASH_DQ_OUT), 8'b1101);
    chk("a1.oe",  8'(bus.oFLASH_DQ_OE), 8'b1101);
    chk("a1.viol", 8'(bus.oVIOL), 8'd0);
    bus.iA_MOSI = 0; bus.iA_SCK = 0;
    step();
    chk("a1.out0", 8'(bus.oFLASH_DQ_OUT), 8'b1100);
    chk("a1.oe0",  8'(bus.oFLASH_DQ_OE), 8'b1101);

    // tie from reset goes to A, then 4-cycle turnaround before B
    iRESET = 1; bus.iA_REQ = 0; bus.iA_CSn = 1;
    step();
    iRESET = 0;
    bus.iA_REQ = 1; bus.iB_REQ = 1;
    step();
    chk("tie.a_gnt", 8'(bus.oA_GNT), 8'd1);
    chk("tie.b_gnt", 8'(bus.oB_GNT), 8'd0);
    bus.iA_REQ = 0;
    step();
    chk("rel.a_gnt", 8'(bus.oA_GNT), 8'd0);
    chk("rel.csn", 8'(bus.oFLASH_CSn), 8'd1);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("turn%0d.b_gnt", k), 8'(bus.oB_GNT), 8'd0);
      chk_pad_idle($sformatf("turn%0d", k));
    end
    step();
    chk("turn.b_gnt", 8'(bus.oB_GNT), 8'd1);

    // B frame: quad pads, WP/HOLD forced high when released
    bus.iB_CSn = 0; bus.iB_SCK = 1; bus.iB_DQ_OUT = 4'b1010; bus.iB_DQ_OE = 4'b1111;
    step();
    chk("b.csn", 8'(bus.oFLASH_CSn), 8'd0);
    chk("b.sck", 8'(bus.oFLASH_SCK), 8'd1);
    chk("b.out", 8'(bus.oFLASH_DQ_OUT), 8'b1010);
    chk("b.oe",  8'(bus.oFLASH_DQ_OE), 8'b1111);
    bus.iB_DQ_OUT = 4'b1110; bus.iB_DQ_OE = 4'b0001;
    step();
    chk("b.out2", 8'(bus.oFLASH_DQ_OUT), 8'b1110);
    chk("b.oe2",  8'(bus.oFLASH_DQ_OE), 8'b1101);

    // B drops REQ mid-frame while A waits: grant held until CSn high
    bus.iB_REQ = 0; bus.iA_REQ = 1;
    step(3);
    chk("mid.b_gnt", 8'(bus.oB_GNT), 8'd1);
    chk("mid.a_gnt", 8'(bus.oA_GNT), 8'd0);
    bus.iB_CSn = 1;
    step();
    chk("mid.rel", 8'(bus.oB_GNT), 8'd0);
    chk("mid.sck_gated", 8'(bus.oFLASH_SCK), 8'd0);
    step(4);
    chk("mid.a_wait", 8'(bus.oA_GNT), 8'd0);
    step();
    chk("mid.a_gnt2", 8'(bus.oA_GNT), 8'd1);

    // hand back to B, then revoke idle B with a CS pulse restarting the count
    bus.iA_REQ = 0; bus.iB_REQ = 1;
    step(6);
    chk("rv.b_gnt", 8'(bus.oB_GNT), 8'd1);
    bus.iA_REQ = 1;
    step(40);
    bus.iB_CSn = 0;
    step();
    bus.iB_CSn = 1;
    step(23);
    chk("rv.hold64", 8'(bus.oB_GNT), 8'd1);
    step(40);
    chk("rv.hold63", 8'(bus.oB_GNT), 8'd1);
    step();
    chk("rv.revoked", 8'(bus.oB_GNT), 8'd0);
    step(5);
    chk("rv.a_gnt", 8'(bus.oA_GNT), 8'd1);

    // non-owner B asserting CSn: violation pulses, pads follow A only
    bus.iB_REQ = 0; bus.iA_CSn = 0; bus.iB_CSn = 0;
    step();
    chk("v1.viol", 8'(bus.oVIOL), 8'd1);
    chk("v1.csn", 8'(bus.oFLASH_CSn), 8'd0);
    bus.iA_CSn = 1;
    step();
    chk("v2.viol", 8'(bus.oVIOL), 8'd1);
    chk("v2.csn", 8'(bus.oFLASH_CSn), 8'd1);
    bus.iB_CSn = 1;
    step();
    chk("v3.viol", 8'(bus.oVIOL), 8'd0);

    // reset in the middle of a B transfer; following tie must go to A
    bus.iA_REQ = 0; bus.iB_REQ = 1;
    step(6);
    chk("r.b_gnt", 8'(bus.oB_GNT), 8'd1);
    bus.iB_CSn = 0; bus.iB_DQ_OE = 4'b1111;
    step();
    chk("r.csn_lo", 8'(bus.oFLASH_CSn), 8'd0);
    iRESET = 1;
    step();
    chk("r.a_gnt", 8'(bus.oA_GNT), 8'd0);
    chk("r.b_gnt0", 8'(bus.oB_GNT), 8'd0);
    chk("r.viol", 8'(bus.oVIOL), 8'd0);
    chk_pad_idle("r");
    iRESET = 0; bus.iB_CSn = 1; bus.iA_REQ = 1; bus.iB_REQ = 1;
    step();
    chk("r.tie_a", 8'(bus.oA_GNT), 8'd1);
    chk("r.tie_b", 8'(bus.oB_GNT), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
